// File: rtl/cpu_pkg.sv
// Shared core definitions: fetch FSM encoding, PC step and default widths.
package cpu_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          INST_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_INC       = 4;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch stage bus: redirect input, imem request/response, decode handshake.
interface inst_fetch_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
);

    logic              i_redirect;
    logic [ADDR_W-1:0] i_redirect_pc;
    logic              o_imem_req;
    logic [ADDR_W-1:0] o_imem_addr;
    logic              i_imem_valid;
    logic [INST_W-1:0] i_imem_inst;
    logic              o_inst_valid;
    logic [INST_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_inst_pc;
    logic              i_inst_ready;

    modport master (
        input  i_redirect,
        input  i_redirect_pc,
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_valid,
        input  i_imem_inst,
        output o_inst_valid,
        output o_inst,
        output o_inst_pc,
        input  i_inst_ready
    );

    modport slave (
        output i_redirect,
        output i_redirect_pc,
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_valid,
        output i_imem_inst,
        input  o_inst_valid,
        input  o_inst,
        input  o_inst_pc,
        output i_inst_ready
    );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the fetch PC, one outstanding imem request,
// and a single-entry buffer toward decode.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter int              INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    inst_fetch_if.master bus
);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [INST_W-1:0] inst_q;
    logic [INST_W-1:0] inst_d;
    logic [ADDR_W-1:0] inst_pc_q;
    logic [ADDR_W-1:0] inst_pc_d;
    logic              valid_q;
    logic              valid_d;
    logic              req;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] redirect_tgt;

    assign pc_inc       = pc_q + ADDR_W'(PC_INC);
    assign redirect_tgt = {bus.i_redirect_pc[ADDR_W-1:2], 2'b00};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        req       = 1'b0;

        unique case (state_q)
            S_REQ: begin
                req = !bus.i_redirect;
                if (bus.i_redirect) begin
                    pc_d = redirect_tgt;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                unique case (1'b1)
                    bus.i_imem_valid && !bus.i_redirect: begin
                        inst_d    = bus.i_imem_inst;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_inc;
                        state_d   = S_HOLD;
                    end
                    bus.i_imem_valid && bus.i_redirect: begin
                        pc_d    = redirect_tgt;
                        state_d = S_REQ;
                    end
                    !bus.i_imem_valid && bus.i_redirect: begin
                        pc_d    = redirect_tgt;
                        state_d = S_FLUSH;
                    end
                    default: begin
                        state_d = S_WAIT;
                    end
                endcase
            end

            // The stale response must still drain before a new request.
            S_FLUSH: begin
                if (bus.i_redirect) begin
                    pc_d = redirect_tgt;
                end
                if (bus.i_imem_valid) begin
                    state_d = S_REQ;
                end
            end

            S_HOLD: begin
                if (bus.i_redirect) begin
                    valid_d = 1'b0;
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (bus.i_inst_ready) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
        endcase
    end

    assign bus.o_imem_req   = req;
    assign bus.o_imem_addr  = pc_q;
    assign bus.o_inst_valid = valid_q;
    assign bus.o_inst       = inst_q;
    assign bus.o_inst_pc    = inst_pc_q;

    valid_tracks_hold: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        valid_q == (state_q == S_HOLD)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch against a transaction-level PC model.
module tb_inst_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

    inst_fetch #(
        .ADDR_W   (32),
        .INST_W   (32),
        .RESET_PC (RST_PC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // memory responder and reference model state
    int          cyc = 0;
    int          due = 0;
    int          lat_fix = 1;
    bit          lat_rand = 1'b0;
    bit          outst = 1'b0;
    bit          live = 1'b0;
    bit          resp_now = 1'b0;
    logic [31:0] resp_addr = '0;
    logic [31:0] exp_pc = RST_PC;

    bit          p_valid = 1'b0;
    bit          p_rdy = 1'b0;
    bit          p_redir = 1'b0;
    bit          p_resp = 1'b0;
    bit          p_live = 1'b0;
    logic [31:0] p_inst = '0;
    logic [31:0] p_pc = '0;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_inst;
    logic [31:0] s_pc;

    task automatic do_cycle(input bit redir, input logic [31:0] tgt,
                            input bit rdy);
        int l;
        @(negedge clk);
        resp_now             = outst && (cyc == due);
        bus.i_imem_valid     = resp_now;
        bus.i_imem_inst      = resp_now ? mem_word(resp_addr) : $urandom;
        bus.i_redirect       = redir;
        bus.i_redirect_pc    = tgt;
        bus.i_inst_ready     = rdy;
        #1;
        s_req   = bus.o_imem_req;
        s_addr  = bus.o_imem_addr;
        s_valid = bus.o_inst_valid;
        s_inst  = bus.o_inst;
        s_pc    = bus.o_inst_pc;

        if (p_valid) begin
            if (p_rdy || p_redir) begin
                chk("drop", 32'(s_valid), 32'd0);
            end else begin
                chk("hold_v", 32'(s_valid), 32'd1);
                chk("hold_inst", s_inst, p_inst);
                chk("hold_pc", s_pc, p_pc);
            end
        end else if (p_resp) begin
            chk("resp_v", 32'(s_valid), 32'(p_live && !p_redir));
        end else begin
            chk("spur_v", 32'(s_valid), 32'd0);
        end

        if (s_req) begin
            chk("one_out", 32'(outst), 32'd0);
            chk("req_addr", s_addr, exp_pc);
            chk("req_hold", 32'(s_valid), 32'd0);
        end

        if (s_valid && rdy) begin
            chk("xfer_pc", s_pc, exp_pc);
            chk("xfer_inst", s_inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
        end

        p_live = live;
        if (resp_now) outst = 1'b0;
        if (redir) live = 1'b0;
        if (s_req) begin
            l         = lat_rand ? int'($urandom_range(1, 4)) : lat_fix;
            outst     = 1'b1;
            live      = 1'b1;
            resp_addr = s_addr;
            due       = cyc + l;
        end
        if (redir) exp_pc = {tgt[31:2], 2'b00};

        p_valid = s_valid;
        p_rdy   = rdy;
        p_redir = redir;
        p_resp  = resp_now;
        p_inst  = s_inst;
        p_pc    = s_pc;
        cyc++;
    endtask

    task automatic run_until_req(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            do_cycle(1'b0, 32'd0, 1'b1);
            seen = s_req;
        end
        if (!seen) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic run_until_valid(input string tag, input bit rdy);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            do_cycle(1'b0, 32'd0, rdy);
            seen = s_valid;
        end
        if (!seen) chk(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int rq[$];
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        bus.i_imem_valid  = 1'b0;
        bus.i_imem_inst   = '0;
        bus.i_inst_ready  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(bus.o_inst_valid), 32'd0);
        chk("rst_inst", bus.o_inst, 32'd0);
        chk("rst_ipc", bus.o_inst_pc, 32'd0);
        chk("rst_addr", bus.o_imem_addr, RST_PC);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // L=1 streaming from reset
        lat_fix = 1;
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b0, 32'd0, 1'b1);
            if (i == 0) begin
                chk("first_req", 32'(s_req), 32'd1);
                chk("first_addr", s_addr, RST_PC);
            end
            if (s_req) rq.push_back(cyc - 1);
        end
        chk("tput_n", 32'(rq.size() >= 3), 32'd1);
        if (rq.size() >= 3) begin
            chk("tput0", 32'(rq[1] - rq[0]), 32'd3);
            chk("tput1", 32'(rq[2] - rq[1]), 32'd3);
        end

        // L=3, decode stalls for 5 cycles
        lat_fix = 3;
        run_until_valid("p2_timeout", 1'b0);
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 32'd0, 1'b0);
            chk("p2_noreq", 32'(s_req), 32'd0);
        end
        do_cycle(1'b0, 32'd0, 1'b1);
        do_cycle(1'b0, 32'd0, 1'b1);
        chk("p2_req", 32'(s_req), 32'd1);

        // redirect while waiting, stale response two cycles later
        run_until_req("p3_timeout");
        do_cycle(1'b1, 32'h0000_2002, 1'b1);
        run_until_req("p3_timeout2");
        chk("p3_addr", s_addr, 32'h0000_2000);

        // redirect coinciding with the response
        lat_fix = 2;
        run_until_req("p4_timeout");
        do_cycle(1'b0, 32'd0, 1'b1);
        do_cycle(1'b1, 32'h0000_0400, 1'b1);
        do_cycle(1'b0, 32'd0, 1'b1);
        chk("p4_req", 32'(s_req), 32'd1);
        chk("p4_addr", s_addr, 32'h0000_0400);

        // redirect in the request cycle
        lat_fix = 1;
        run_until_valid("p5_timeout", 1'b1);
        do_cycle(1'b1, 32'h0000_0800, 1'b1);
        chk("p5_supp", 32'(s_req), 32'd0);
        do_cycle(1'b0, 32'd0, 1'b1);
        chk("p5_req", 32'(s_req), 32'd1);
        chk("p5_addr", s_addr, 32'h0000_0800);

        // PC wrap at the top of the address space
        do_cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        run_until_req("p6_timeout");
        chk("p6_pc", s_addr, 32'hFFFF_FFFC);
        run_until_req("p6_timeout2");
        chk("p6_wrap", s_addr, 32'h0000_0000);

        // random traffic
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            do_cycle($urandom_range(0, 19) == 0, $urandom,
                     $urandom_range(0, 2) != 0);
        end

        // asynchronous reset mid-cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_inst_valid), 32'd0);
        chk("arst_addr", bus.o_imem_addr, RST_PC);
        chk("arst_ipc", bus.o_inst_pc, 32'd0);
        bus.i_imem_valid = 1'b0;
        bus.i_redirect   = 1'b0;
        outst   = 1'b0;
        live    = 1'b0;
        exp_pc  = RST_PC;
        p_valid = 1'b0;
        p_resp  = 1'b0;
        p_redir = 1'b0;
        p_rdy   = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        lat_rand = 1'b0;
        lat_fix  = 1;
        do_cycle(1'b0, 32'd0, 1'b1);
        chk("arst_req", 32'(s_req), 32'd1);
        for (int i = 0; i < 12; i++) do_cycle(1'b0, 32'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch stage between the program counter logic and the decode stage. It owns the architectural fetch PC and issues one request at a time to instruction memory, which has a variable latency of at least 1 cycle. It buffers the returned instruction with its PC and presents both to decode under a valid/ready handshake. Branch and jump redirects from execute squash any in-flight or held fetch.

Parameters:
ADDR_W, 32, width of PC and instruction memory address (byte address, at least 3)
INST_W, 32, instruction width
RESET_PC, 0, PC value after reset (word-aligned)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_redirect  in  1  taken branch/jump from execute; pulse, may occur in any state
i_redirect_pc  in  ADDR_W  redirect target
o_imem_req  out  1  one-cycle request strobe to instruction memory
o_imem_addr  out  ADDR_W  request address, equals current PC
i_imem_valid  in  1  response strobe, one cycle, only after a request
i_imem_inst  in  INST_W  response data, qualified by i_imem_valid
o_inst_valid  out  1  decode-side valid
o_inst  out  INST_W  held instruction
o_inst_pc  out  ADDR_W  PC of o_inst
i_inst_ready  in  1  decode accepts; transfer = o_inst_valid & i_inst_ready

Behaviour:
- Reset (async assert, sync release):
  - pc = RESET_PC, state = S_REQ
  - o_inst_valid = 0, o_inst = 0, o_inst_pc = 0
  - o_imem_req = 1 on the first cycle after release, with o_imem_addr = RESET_PC
- At most one outstanding request.
- o_imem_addr = pc at all times.
- Redirect target: bits [1:0] forced to 0 before loading into pc.
- PC increment is pc + 4, modulo 2^ADDR_W. 0xFFFF_FFFC wraps to 0x0000_0000 silently.
- FSM states:
  - S_REQ:
    - o_imem_req = !i_redirect.
    - No redirect: go to S_WAIT.
    - Redirect: pc <= target, suppress the request, stay in S_REQ.
  - S_WAIT:
    - i_imem_valid & !i_redirect: o_inst <= i_imem_inst, o_inst_pc <= pc, o_inst_valid <= 1, pc <= pc+4, go to S_HOLD.
    - i_imem_valid & i_redirect: discard data, pc <= target, go to S_REQ.
    - !i_imem_valid & i_redirect: pc <= target, go to S_FLUSH.
  - S_FLUSH:
    - Waits for the stale response.
    - On i_imem_valid: discard it, go to S_REQ.
    - A further redirect while here: pc <= new target, stay in S_FLUSH.
  - S_HOLD:
    - o_inst_valid = 1; o_inst and o_inst_pc stay stable until transfer.
    - Transfer: o_inst_valid <= 0, go to S_REQ.
    - Redirect (with or without ready): o_inst_valid <= 0, pc <= target, go to S_REQ. A simultaneous transfer still counts as accepted by decode; squashing it is decode's responsibility.
- Latency: request issued at cycle T, response at T+L (L ≥ 1), o_inst_valid high from T+L+1.
  - Steady-state throughput: one instruction per L+2 cycles with ready held high.
- i_imem_valid in S_REQ or S_HOLD is a protocol error: ignore it and do not change state.
- o_inst_valid never drops without a transfer or a redirect.

Decomposition:
- Shared package cpu_pkg:
  - fetch state encoding (S_REQ, S_WAIT, S_FLUSH, S_HOLD; 2-bit)
  - PC_INC = 4
  - the default parameter constants
- No sub-module is required. Keep the FSM, the PC register and the output buffer in one module; the PC incrementer is a single adder.

Test Plan:
- Reset with RESET_PC=0x100, L=1, ready=1 → requests at 0x100, 0x104, 0x108; o_inst_pc sequence matches; one instruction every 3 cycles.
- L=3, i_inst_ready held 0 for 5 cycles in S_HOLD → o_inst and o_inst_pc stable; no new o_imem_req until ready=1.
- Redirect to 0x2002 in S_WAIT, response arrives 2 cycles later → response discarded (never valid downstream); next request addr 0x2000.
- Redirect to 0x400 in the same cycle as i_imem_valid → data dropped; next cycle o_imem_req=1, addr 0x400.
- Redirect in S_REQ → o_imem_req stays low that cycle; next cycle requests the target.
- pc=0xFFFF_FFFC fetched and accepted → next request address 0x0000_0000.
